trace_check_unit: RTL

TRACE_CHECK_UNIT -- requirements
Module: trace_check_unit

---
 rtl/trace_check_unit_if.sv | 31 +++
 rtl/trace_check_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/trace_check_unit_if.sv
// Expected-trace and commit-lane streams for trace_check_unit; slave is the checker side.
// Valid/ready on both streams; per-lane commit payloads are packed lane 0 in the LSBs.
interface trace_check_unit_if #(
  parameter int p_num_ports = 2
);
  logic                       exp_val;
  logic                       exp_rdy;
  logic [31:0]                exp_pc;
  logic [4:0]                 exp_waddr;
  logic [31:0]                exp_wdata;
  logic                       exp_wen;

  logic [p_num_ports-1:0]     cmt_val;
  logic [32*p_num_ports-1:0]  cmt_pc;
  logic [5*p_num_ports-1:0]   cmt_waddr;
  logic [32*p_num_ports-1:0]  cmt_wdata;
  logic [p_num_ports-1:0]     cmt_wen;
  logic                       cmt_rdy;

  modport master (
    output exp_val, exp_pc, exp_waddr, exp_wdata, exp_wen,
    output cmt_val, cmt_pc, cmt_waddr, cmt_wdata, cmt_wen,
    input  exp_rdy, cmt_rdy
  );

  modport slave (
    input  exp_val, exp_pc, exp_waddr, exp_wdata, exp_wen,
    input  cmt_val, cmt_pc, cmt_waddr, cmt_wdata, cmt_wen,
    output exp_rdy, cmt_rdy
  );
endinterface

// File: rtl/trace_check_unit.sv
// Compares DUT commit lanes against a FIFO of expected trace entries; status one cycle after a commit.
// exp_rdy drops when the FIFO is full; cmt_rdy only when a full lane group is queued; FAIL never stalls.
module trace_check_unit #(
  parameter int p_num_ports = 2,
  parameter int p_depth     = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  trace_check_unit_if.slave                                   bus,
  output logic                                                err,
  output logic [2:0]                                          err_cause,
  output logic [((p_num_ports > 1) ? $clog2(p_num_ports) : 1)-1:0] err_lane,
  output logic [31:0]                                         err_pc,
  output logic [31:0]                                         match_count,
  output logic                                                empty
);
  localparam int lc_aw = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int lc_cw = $clog2(p_depth + 1);
  localparam int lc_lw = (p_num_ports > 1) ? $clog2(p_num_ports) : 1;

  localparam logic [0:0] st_check = 1'b0;
  localparam logic [0:0] st_fail  = 1'b1;

  localparam logic [2:0] c_none  = 3'b000;
  localparam logic [2:0] c_pc    = 3'b001;
  localparam logic [2:0] c_wen   = 3'b010;
  localparam logic [2:0] c_data  = 3'b011;
  localparam logic [2:0] c_proto = 3'b100;

  logic [31:0]      mem_pc    [p_depth];
  logic [4:0]       mem_waddr [p_depth];
  logic [31:0]      mem_wdata [p_depth];
  logic             mem_wen   [p_depth];

  logic [lc_aw-1:0] head;
  logic [lc_aw-1:0] tail;
  logic [lc_cw-1:0] count;
  logic [0:0]       state;

  logic             enq;
  logic             fire;
  logic [lc_cw-1:0] n_deq;
  logic             proto_err;
  logic [lc_lw-1:0] proto_lane;
  logic             lane_fail;
  logic [lc_lw-1:0] fail_lane;
  logic [2:0]       fail_cause;
  logic [31:0]      fail_pc;
  logic [2:0]       match_add;
  logic [32:0]      match_sum;

  logic [lc_aw-1:0] lane_idx   [p_num_ports];
  logic [2:0]       lane_cause [p_num_ports];

  assign bus.exp_rdy = !rst && (count < lc_cw'(p_depth));
  assign bus.cmt_rdy = !rst && (count >= lc_cw'(p_num_ports));
  assign enq         = bus.exp_val && bus.exp_rdy;
  assign fire        = bus.cmt_rdy && (bus.cmt_val != '0);
  assign empty       = rst || (count == '0);
  assign err         = (state == st_fail);
  assign match_sum   = {1'b0, match_count} + 33'(match_add);

  // Per-lane verdict against entry head+i; waddr/wdata only matter for writing commits.
  always_comb begin
    for (int i = 0; i < p_num_ports; i++) begin
      lane_idx[i]   = lc_aw'((int'(head) + i) % p_depth);
      lane_cause[i] = c_none;
      if (bus.cmt_pc[32*i +: 32] != mem_pc[lane_idx[i]])
        lane_cause[i] = c_pc;
      else if (bus.cmt_wen[i] != mem_wen[lane_idx[i]])
        lane_cause[i] = c_wen;
      else if (bus.cmt_wen[i] &&
               ((bus.cmt_waddr[5*i +: 5] != mem_waddr[lane_idx[i]]) ||
                (bus.cmt_wdata[32*i +: 32] != mem_wdata[lane_idx[i]])))
        lane_cause[i] = c_data;
    end
  end

  always_comb begin
    n_deq      = '0;
    proto_err  = 1'b0;
    proto_lane = '0;
    lane_fail  = 1'b0;
    fail_lane  = '0;
    fail_cause = c_none;
    fail_pc    = '0;
    match_add  = '0;
    for (int i = 0; i < p_num_ports; i++)
      if (bus.cmt_val[i]) n_deq = n_deq + lc_cw'(1);
    for (int i = 0; i < p_num_ports - 1; i++)
      if (!proto_err && !bus.cmt_val[i] && ((bus.cmt_val >> (i + 1)) != '0)) begin
        proto_err  = 1'b1;
        proto_lane = lc_lw'(i);
      end
    for (int i = 0; i < p_num_ports; i++)
      if (bus.cmt_val[i] && !lane_fail) begin
        if (lane_cause[i] != c_none) begin
          lane_fail  = 1'b1;
          fail_lane  = lc_lw'(i);
          fail_cause = lane_cause[i];
          fail_pc    = bus.cmt_pc[32*i +: 32];
        end else begin
          match_add = match_add + 3'(1);
        end
      end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_pc[tail]    <= bus.exp_pc;
      mem_waddr[tail] <= bus.exp_waddr;
      mem_wdata[tail] <= bus.exp_wdata;
      mem_wen[tail]   <= bus.exp_wen;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      state       <= st_check;
      err_cause   <= c_none;
      err_lane    <= '0;
      err_pc      <= '0;
      match_count <= '0;
    end else begin
      if (enq)
        tail <= lc_aw'((int'(tail) + 1) % p_depth);
      if (fire)
        head <= lc_aw'((int'(head) + int'(n_deq)) % p_depth);
      count <= count + (enq ? lc_cw'(1) : '0) - (fire ? n_deq : '0);

      // A malformed lane group is not credited with any matches.
      if (fire && (state == st_check)) begin
        if (proto_err) begin
          state     <= st_fail;
          err_cause <= c_proto;
          err_lane  <= proto_lane;
          err_pc    <= bus.cmt_pc[31:0];
        end else begin
          match_count <= match_sum[32] ? 32'hFFFF_FFFF : match_sum[31:0];
          if (lane_fail) begin
            state     <= st_fail;
            err_cause <= fail_cause;
            err_lane  <= fail_lane;
            err_pc    <= fail_pc;
          end
        end
      end
    end
  end
endmodule
